// File: rtl/pixel_upscaler_3x_pkg.sv
// Shared constants and arithmetic helpers for the 3x pixel upscaler.
// Provides counter sizing and exact divide-by-3 for the interpolation sums.
package upscaler_pkg;

  localparam int SCALE = 3;
  localparam int PIX_W = 8;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // x*683 >> 11 is exact floor(x/3) for every 10-bit x
  function automatic logic [PIX_W-1:0] div3(input logic [9:0] x);
    logic [20:0] p;
    p = 21'(x) * 21'd683;
    return p[18:11];
  endfunction

endpackage

// File: rtl/pixel_upscaler_3x_if.sv
// Pixel stream bundle between the frame feeder, the upscaler and the pixel sink.
// slave = upscaler side, master = feeder/sink side.
interface pixel_upscaler_3x_if;
  logic [7:0] pixel_in;
  logic       input_valid;
  logic [7:0] pixel_out;
  logic       output_valid;

  modport slave  (input  pixel_in, input_valid, output pixel_out, output_valid);
  modport master (output pixel_in, input_valid, input  pixel_out, output_valid);
endinterface

// File: rtl/pixel_upscaler_3x_blend3.sv
// Combinational 3-phase blend: phase0 (2A+B)/3, phase1 (A+2B)/3, phase2 B.
module upscaler_blend3
  import upscaler_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [1:0]       phase_i,
  output logic [PIX_W-1:0] y_o
);

  logic [9:0] sum_aab;
  logic [9:0] sum_abb;

  assign sum_aab = {1'b0, a_i, 1'b0} + 10'(b_i);
  assign sum_abb = 10'(a_i) + {1'b0, b_i, 1'b0};

  always_comb begin
    y_o = b_i;
    case (phase_i)
      2'd0:    y_o = div3(sum_aab);
      2'd1:    y_o = div3(sum_abb);
      default: y_o = b_i;
    endcase
  end

endmodule

// File: rtl/pixel_upscaler_3x.sv
// Streaming 3x grayscale upscaler: horizontal linear interpolation over feeder-repeated pixels.
// Define UPSCALER_VERT_INTERP_EN for vertical interpolation via a line buffer (latency 1 -> 2).
module pixel_upscaler_3x
  import upscaler_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 72
) (
  input  logic                clk,
  input  logic                rst,
  pixel_upscaler_3x_if.slave  px_if
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  logic [1:0]       hph_q, hph_d;
  logic [1:0]       vph_q, vph_d;
  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [PIX_W-1:0] a_q, a_d;
  logic [PIX_W-1:0] a_eff;
  logic [PIX_W-1:0] h_pix;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             vld_q;

  always_comb begin
    hph_d = hph_q;
    vph_d = vph_q;
    col_d = col_q;
    row_d = row_q;
    a_d   = a_q;
    if (px_if.input_valid) begin
      if (hph_q == 2'd2) begin
        hph_d = 2'd0;
        a_d   = px_if.pixel_in;
        if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          if (vph_q == 2'd2) begin
            vph_d = 2'd0;
            row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
          end else begin
            vph_d = vph_q + 2'd1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        hph_d = hph_q + 2'd1;
      end
    end
  end

  // Left edge replicates the first pixel instead of blending with stale A
  assign a_eff = (col_q == '0) ? px_if.pixel_in : a_q;

  upscaler_blend3 u_hblend (
    .a_i     (a_eff),
    .b_i     (px_if.pixel_in),
    .phase_i (hph_q),
    .y_o     (h_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hph_q <= '0;
      vph_q <= '0;
      col_q <= '0;
      row_q <= '0;
      a_q   <= '0;
    end else begin
      hph_q <= hph_d;
      vph_q <= vph_d;
      col_q <= col_d;
      row_q <= row_d;
      a_q   <= a_d;
    end
  end

`ifdef UPSCALER_VERT_INTERP_EN
  localparam int LB_D = SCALE * IMG_W;
  localparam int IW   = cnt_w(LB_D);

  logic [PIX_W-1:0] lbuf [LB_D];
  logic [IW-1:0]    lb_idx;
  logic [PIX_W-1:0] u_q;
  logic [PIX_W-1:0] h_s1_q;
  logic [1:0]       vph_s1_q;
  logic             row0_s1_q;
  logic             vld_s1_q;
  logic [PIX_W-1:0] u_eff;
  logic [PIX_W-1:0] v_pix;

  assign lb_idx = IW'(col_q) * IW'(SCALE) + IW'(hph_q);

  // Same-index read/write only happens on vph2, where U is not used
  always_ff @(posedge clk) begin
    if (px_if.input_valid) begin
      u_q <= lbuf[lb_idx];
      if (vph_q == 2'd2) lbuf[lb_idx] <= h_pix;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_s1_q    <= '0;
      vph_s1_q  <= '0;
      row0_s1_q <= 1'b0;
      vld_s1_q  <= 1'b0;
    end else begin
      vld_s1_q <= px_if.input_valid;
      if (px_if.input_valid) begin
        h_s1_q    <= h_pix;
        vph_s1_q  <= vph_q;
        row0_s1_q <= (row_q == '0);
      end
    end
  end

  assign u_eff = row0_s1_q ? h_s1_q : u_q;

  upscaler_blend3 u_vblend (
    .a_i     (u_eff),
    .b_i     (h_s1_q),
    .phase_i (vph_s1_q),
    .y_o     (v_pix)
  );

  assign pix_d = vld_s1_q ? v_pix : pix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      vld_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      vld_q <= vld_s1_q;
    end
  end
`else
  assign pix_d = px_if.input_valid ? h_pix : pix_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q <= '0;
      vld_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      vld_q <= px_if.input_valid;
    end
  end
`endif

  assign px_if.pixel_out    = pix_q;
  assign px_if.output_valid = vld_q;

endmodule

// File: tb/tb_pixel_upscaler_3x.sv
// Randomized + directed bench for pixel_upscaler_3x against a position-arithmetic reference model.
module tb_pixel_upscaler_3x;

  localparam int W = 8;
  localparam int H = 4;
  localparam int FRAME = 9 * W * H;
`ifdef UPSCALER_VERT_INTERP_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_upscaler_3x_if px_if ();

  pixel_upscaler_3x #(.IMG_W(W), .IMG_H(H)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .px_if (px_if)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int out_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position derived from the beat index within the frame
  int beat_n = 0;
  int prev_b = 0;
  int lbuf [3*W];
  int exp_q [$];

  task automatic predict(input int b, output int y);
    int hph, col, vph, row, a, hv;
    hph = beat_n % 3;
    col = (beat_n / 3) % W;
    vph = (beat_n / (3 * W)) % 3;
    row = beat_n / (9 * W);
    a   = (col == 0) ? b : prev_b;
    hv  = (hph == 0) ? (2 * a + b) / 3 : (hph == 1) ? (a + 2 * b) / 3 : b;
    y   = hv;
`ifdef UPSCALER_VERT_INTERP_EN
    begin
      int idx, u;
      idx = col * 3 + hph;
      u   = (row == 0) ? hv : lbuf[idx];
      y   = (vph == 0) ? (2 * u + hv) / 3 : (vph == 1) ? (u + 2 * hv) / 3 : hv;
      if (vph == 2) lbuf[idx] = hv;
    end
`else
    if (vph < 0 || row < 0) y = -1;
`endif
    if (hph == 2) prev_b = b;
    beat_n = (beat_n + 1) % FRAME;
  endtask

  task automatic beat(input int b);
    int y;
    @(posedge clk); #1;
    px_if.pixel_in    = b[7:0];
    px_if.input_valid = 1'b1;
    predict(b, y);
    exp_q.push_back(y);
  endtask

  task automatic gap();
    @(posedge clk); #1;
    px_if.input_valid = 1'b0;
    px_if.pixel_in    = 8'($urandom);
  endtask

  // One source row pass: each pixel on 3 beats, 1-cycle blanking at row end
  task automatic send_pass(input int rp [W], input bit gaps, input bit jitter);
    for (int c = 0; c < W; c++) begin
      for (int h = 0; h < 3; h++) begin
        if (gaps && $urandom_range(0, 4) == 0) gap();
        if (jitter && $urandom_range(0, 7) == 0) beat(int'($urandom_range(0, 255)));
        else beat(rp[c]);
      end
    end
    gap();
  endtask

  task automatic send_row(input int rp [W], input bit gaps, input bit jitter);
    for (int p = 0; p < 3; p++) send_pass(rp, gaps, jitter);
  endtask

  task automatic fill_row(output int rp [W], input int v);
    for (int c = 0; c < W; c++) rp[c] = (v < 0) ? int'($urandom_range(0, 255)) : v;
  endtask

  task automatic drain();
    repeat (LAT + 2) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Output monitor: valid timing, pixel values, and hold while idle
  logic [3:0] vpipe;
  logic [7:0] last_pix;

  always @(posedge clk or posedge rst) begin
    if (rst) vpipe <= '0;
    else     vpipe <= {vpipe[2:0], px_if.input_valid};
  end

  always @(negedge clk) begin
    if (rst) begin
      last_pix = 8'd0;
    end else begin
      chk("out_valid", px_if.output_valid, vpipe[LAT-1]);
      if (px_if.output_valid === 1'b1) begin
        out_cnt++;
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("pix", px_if.pixel_out, exp_q.pop_front());
        last_pix = px_if.pixel_out;
      end else begin
        chk("hold", px_if.pixel_out, last_pix);
      end
    end
  end

  initial begin
    int rp [W];
    int base;

    rst = 1'b1;
    px_if.input_valid = 1'b1;
    px_if.pixel_in    = 8'hAB;
    repeat (3) @(negedge clk);
    chk("rst_pix", px_if.pixel_out, 0);
    chk("rst_vld", px_if.output_valid, 0);
    px_if.input_valid = 1'b0;
    rst = 1'b0;

    // Frame 1: ramp, two rounding rows, flat row
    fill_row(rp, 8'h30); rp[0] = 8'h00;
    beat(rp[0]);
    gap();
    repeat (LAT) @(negedge clk);
    chk("first_vld", px_if.output_valid, 1);
    beat(rp[0]); beat(rp[0]);
    for (int c = 1; c < W; c++) for (int h = 0; h < 3; h++) beat(rp[c]);
    gap();
    send_pass(rp, 0, 0);
    send_pass(rp, 0, 0);
    fill_row(rp, -1); rp[0] = 8'h01; rp[1] = 8'h00;
    send_row(rp, 0, 0);
    fill_row(rp, -1); rp[0] = 8'hFF; rp[1] = 8'h00;
    send_row(rp, 0, 0);
    fill_row(rp, 8'h80);
    for (int p = 0; p < 3; p++) begin
      drain();
      base = out_cnt;
      send_pass(rp, 1, 0);
      drain();
      chk("row_pass_count", out_cnt - base, 3 * W);
    end

    // Frame 2: uniform 0x00 then 0x30 rows (vertical blend case), then random
    base = out_cnt;
    fill_row(rp, 8'h00); send_row(rp, 0, 0);
    fill_row(rp, 8'h30); send_row(rp, 1, 0);
    fill_row(rp, -1);    send_row(rp, 1, 0);
    fill_row(rp, -1);    send_row(rp, 1, 0);
    drain();
    chk("frame2_count", out_cnt - base, FRAME);

    // Back-to-back random frames with gaps and per-beat sample jitter
    for (int f = 0; f < 3; f++) begin
      base = out_cnt;
      for (int r = 0; r < H; r++) begin
        fill_row(rp, -1);
        send_row(rp, 1, f != 0);
      end
      drain();
      chk("frame_count", out_cnt - base, FRAME);
    end

    // Reset mid-frame, then a full frame must start from row 0 col 0
    fill_row(rp, -1);
    send_row(rp, 1, 0);
    send_pass(rp, 0, 0);
    drain();
    @(posedge clk); #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    beat_n = 0;
    base = out_cnt;
    for (int r = 0; r < H; r++) begin
      fill_row(rp, -1);
      send_row(rp, 1, 0);
    end
    drain();
    chk("post_rst_count", out_cnt - base, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_upscaler_3x.md
Name: pixel_upscaler_3x

Overview:
- Streaming 8-bit grayscale 3x image upscaler with linear interpolation.
- The upstream feeder presents each source pixel on 3 consecutive valid beats, and each source row 3 times.
- The block tracks horizontal/vertical phase and position, then replaces nearest-neighbour repeats with interpolated values.
- Sits between the frame source and the output pixel sink; output is one pixel per valid input beat.

Parameters:
- IMG_W, 128, source image width in pixels (≥2).
- IMG_H, 72, source image height in rows (≥2).

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- rst, input, 1, asynchronous active-high reset.
- pixel_in, input, 8, current source pixel sample.
- input_valid, input, 1, pixel_in valid this cycle; counters advance only when high.
- pixel_out, output, 8, interpolated output pixel.
- output_valid, output, 1, pixel_out valid.

Behaviour:
- Fixed scale factor of 3; no runtime configuration.
- Counters advance once per input_valid beat, in this nesting order:
  - hph: 0..2.
  - col: 0..IMG_W-1, increments when hph wraps.
  - vph: 0..2, increments when col wraps.
  - row: 0..IMG_H-1, increments when vph wraps; wraps to 0 after the last row for back-to-back frames.
- input_valid low: counters and all state hold; gaps of any length (e.g. 1-cycle line blanking) are legal anywhere.
- Register A holds the previous column's sample; B = pixel_in.
- A update rule: A <= B on each valid beat with hph==2.
- At col==0, A is ignored and treated as equal to B (edge replicate).
- Horizontal output H:
  - hph0: floor((2A+B)/3).
  - hph1: floor((A+2B)/3).
  - hph2: B.
- Intermediate sums are 10 bits; the result always fits in 8 bits; no saturation needed.
- Base build: pixel_out = H, so vertical scaling is row repetition as supplied by the feeder.
- Latency is 1 cycle:
  - output_valid = input_valid registered.
  - pixel_out is registered.
  - pixel_out holds its last value while output_valid is low.
- Output count is exactly 9*IMG_W*IMG_H valid beats per frame.
- Reset values: pixel_out=0, output_valid=0; all counters and A = 0.
- Reset mid-frame: the next valid beat is treated as row 0, col 0, hph 0, vph 0.
- pixel_in is expected to be constant across the 3 beats of one column. If it is not, each beat uses its own sample as B, and A latches the hph2 sample.

Optional Feature:
- Macro: UPSCALER_VERT_INTERP_EN.
- When defined:
  - Adds a line buffer of 3*IMG_W x 8 holding the previous source row's H values (written when vph==2, indexed by output column col*3+hph).
  - Output V, with U the buffer value at the same index:
    - vph0: floor((2U+H)/3).
    - vph1: floor((U+2H)/3).
    - vph2: H.
  - Row 0 uses U=H.
  - Buffer read is synchronous, so latency becomes 2 cycles; output_valid is delayed to match.
  - The buffer content is not cleared by reset; row 0 never reads it.
- When undefined: no line buffer, 1-cycle latency as above.

Decomposition:
- Package upscaler_pkg:
  - SCALE=3, PIX_W=8.
  - Counter-width function (clog2).
  - Function div3 (exact floor division of a 10-bit value by 3; a multiply-by-683, shift-right-11 implementation is acceptable).
- Sub-module upscaler_blend3:
  - Inputs: two 8-bit samples and a 2-bit phase.
  - Output: floor((2A+B)/3) / floor((A+2B)/3) / B.
  - Combinational.
  - Instantiated once for horizontal interpolation, and once more under UPSCALER_VERT_INTERP_EN.

Test Plan:
- Reset check: hold rst high with input_valid=1 → pixel_out=0, output_valid=0; after release, the first valid beat yields output_valid=1 one cycle later.
- Flat row: all pixels 0x80 → every output is 0x80, with exactly 3*IMG_W valid outputs per row pass.
- Ramp row, col0=0x00 then col1=0x30 (each 3 beats) → outputs 00,00,00,10,20,30.
- Rounding row: A=0x01, B=0x00 → 00,00,00; then A=0xFF, B=0x00 (col0=FF, col1=00) → FF,FF,FF,AA,55,00.
- Gaps: insert 1-cycle input_valid=0 after each row and random mid-row gaps → output sequence is identical to the gap-free run; a full frame yields 9*128*72=82944 outputs.
- Vertical (UPSCALER_VERT_INTERP_EN): uniform row 0x00 followed by uniform row 0x30 → second-row passes output 0x10, 0x20, 0x30 on every pixel, with 2-cycle latency.
